// File: rtl/salu_writeback_queue_if.sv
// SALU result bus into the writeback queue: valid/ready plus the result payload.
interface salu_writeback_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_dst;
  logic [63:0] in_data;
  logic        in_is64;
  logic        in_scc_we;
  logic        in_scc;

  modport master (output in_valid, in_dst, in_data, in_is64, in_scc_we, in_scc, input in_ready);
  modport slave  (input in_valid, in_dst, in_data, in_is64, in_scc_we, in_scc, output in_ready);
endinterface

// File: rtl/salu_writeback_queue.sv
// In-order SALU writeback FIFO draining one entry per cycle to the SGPR write port,
// dropping writes to protected SGPRs and flagging operand hazards on pending dests.
module salu_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  salu_writeback_queue_if.slave in_if,
  input  logic                  hold,
  input  logic [7:0]            rd_addr0,
  input  logic [7:0]            rd_addr1,
  output logic                  hazard,
  output logic [7:0]            w0,
  output logic [63:0]           wv,
  output logic                  en_w,
  output logic                  en_64,
  output logic                  scc_val,
  output logic                  ro_err,
  output logic [CNT_W-1:0]      count
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0]  dst;
    logic [63:0] data;
    logic        is64;
    logic        scc_we;
    logic        scc;
    logic        ill;
  } entry_t;

  function automatic logic ill_addr(input logic [7:0] a);
    return (a == 8'h7D) || (a >= 8'h80 && a <= 8'hE8) ||
           (a >= 8'hF0 && a <= 8'hF8) || (a >= 8'hFB && a <= 8'hFD);
  endfunction

  function automatic logic hit(input logic [7:0] d, input logic w, input logic [7:0] a);
    return (a == d) || (w && a == d + 8'd1);
  endfunction

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               full, push, pop;
  entry_t             in_e, head;

  assign full         = (count == CNT_W'(DEPTH));
  assign in_if.in_ready = !full;
  assign push         = in_if.in_valid && !full;
  assign pop          = (count != '0) && !hold;
  assign head         = mem[rd_ptr];

  // Legality is resolved at enqueue so drain and hazard logic see one flag.
  // An is64 write at 0xFF would wrap to SGPR 0, which is never allowed.
  always_comb begin
    in_e        = '0;
    in_e.dst    = in_if.in_dst;
    in_e.data   = in_if.in_is64 ? in_if.in_data : {32'b0, in_if.in_data[31:0]};
    in_e.is64   = in_if.in_is64;
    in_e.scc_we = in_if.in_scc_we;
    in_e.scc    = in_if.in_scc;
    in_e.ill    = ill_addr(in_if.in_dst) ||
                  (in_if.in_is64 && (in_if.in_dst == 8'hFF || ill_addr(in_if.in_dst + 8'd1)));
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_e;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      w0      <= '0;
      wv      <= '0;
      en_w    <= 1'b0;
      en_64   <= 1'b0;
      scc_val <= 1'b0;
      ro_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      en_w   <= 1'b0;
      en_64  <= 1'b0;
      ro_err <= 1'b0;
      if (pop) begin
        w0     <= head.dst;
        wv     <= head.data;
        en_w   <= !head.ill;
        en_64  <= !head.ill && head.is64;
        ro_err <= head.ill;
        if (head.scc_we) scc_val <= head.scc;
      end
    end
  end

  // en_64 doubles as the in-flight write's is64 since en_w implies a legal entry.
  always_comb begin
    entry_t e;
    hazard = en_w && (hit(w0, en_64, rd_addr0) || hit(w0, en_64, rd_addr1));
    for (int k = 0; k < DEPTH; k++) begin
      e = mem[rd_ptr + PTR_W'(k)];
      if (CNT_W'(k) < count && !e.ill &&
          (hit(e.dst, e.is64, rd_addr0) || hit(e.dst, e.is64, rd_addr1)))
        hazard = 1'b1;
    end
  end
endmodule

// File: doc/salu_writeback_queue.md
Name: salu_writeback_queue

Overview:
Writeback stage between the scalar ALU and the scalar register file. Buffers SALU results in a small in-order FIFO and drains one per cycle onto the register-file write port (dest address, 64-bit write value, write enable, 64-bit enable, SCC level). Blocks writes to read-only or hardware-owned SGPR addresses. Provides a hazard flag that issue logic uses to stall operand reads of pending destinations.

Parameters:
DEPTH, 4, FIFO entries (power of two, ≥2)
CNT_W, 3, occupancy counter width (log2(DEPTH)+1)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  SALU result valid
in_ready  out  1  queue can accept; equals !full
in_dst  in  8  destination SGPR index
in_data  in  64  result; [31:0] only when in_is64=0
in_is64  in  1  64-bit write to in_dst, in_dst+1
in_scc_we  in  1  result updates SCC
in_scc  in  1  new SCC value
hold  in  1  pause draining; queue still accepts
rd_addr0  in  8  operand-0 index being issued
rd_addr1  in  8  operand-1 index being issued
hazard  out  1  combinational: rd_addr0/1 matches a pending write
w0  out  8  register-file write address
wv  out  64  register-file write value
en_w  out  1  register-file write enable (one-cycle pulse per entry)
en_64  out  1  register-file 64-bit enable
scc_val  out  1  SCC level to register file (sticky)
ro_err  out  1  one-cycle pulse: entry dropped as illegal
count  out  CNT_W  occupancy

Behaviour:
- Reset (async, immediate): FIFO empty, count=0, w0=0, wv=0, en_w=0, en_64=0, scc_val=0, ro_err=0; in_ready=1 after reset.
- Enqueue on edge when in_valid && in_ready. When full, in_ready=0 even if a pop happens the same cycle (no simultaneous push-while-full).
- Drain: on each edge with count>0 and hold=0, pop the head and register outputs from it; outputs are visible the cycle after the pop edge. Without a pop, en_w, en_64 and ro_err return to 0 on that edge; w0/wv keep their last value.
- Latency: accept at edge N into an empty queue -> pop at N+1 -> en_w high during cycle N+1..N+2. Throughput 1 entry/cycle. Simultaneous push+pop leaves count unchanged.
- Illegal destinations: 0x7D, 0x80–0xE8, 0xF0–0xF8, 0xFB–0xFD. An entry is illegal if in_dst is illegal, or in_is64 and in_dst+1 is illegal, or in_is64 and in_dst=0xFF (no wrap). Popping an illegal entry gives en_w=0, en_64=0, ro_err=1. Its SCC update still applies.
- SCC: on pop of an entry with scc_we=1, scc_val <= scc. Otherwise scc_val holds, because the register file samples SCC every cycle.
- wv = in_data for 64-bit entries, {32'b0, in_data[31:0]} for 32-bit entries. en_64 = is64 for legal entries.
- Hazard: asserts if either rd_addr equals the dst, or dst+1 when is64, of (a) any valid FIFO entry, or (b) the write currently driven with en_w=1. Illegal entries never raise hazard. An incoming in_valid entry not yet accepted does not count.
- hold=1 freezes drain state; en_w drops after one cycle. The FIFO fills to DEPTH, then in_ready=0.
- Pointers wrap modulo DEPTH; count tracks 0..DEPTH exactly.

Test Plan:
- Reset mid-drain: 3 entries queued, reset_n low -> en_w=0, count=0, scc_val=0 immediately; in_ready=1.
- Single 32-bit write: dst=0x05, data=0xDEADBEEF_12345678 at edge N -> edge N+1 drives w0=0x05, wv=0x00000000_12345678, en_w=1, en_64=0 for exactly one cycle.
- Back-to-back: 4 entries dst 0x10..0x13 on consecutive cycles with hold=0 -> four consecutive en_w pulses in order; count never exceeds 1.
- Fill/stall: hold=1, push 5 entries -> count=4, in_ready=0, 5th not accepted; release hold -> 4 pops in order, in_ready=1 after the first pop.
- Illegal: dst=0x80, then is64 dst=0x7C, then is64 dst=0xFF, each with scc_we=1, scc=1 -> three ro_err pulses, en_w never high, scc_val=1.
- Hazard: queue holds is64 dst=0x20 -> rd_addr0=0x21 gives hazard=1; rd_addr1=0x22 gives 0; hazard stays 1 through the en_w cycle and is 0 the cycle after.
